// File: rtl/lpc_cycle_fifo.sv
// lpc_cycle_fifo: captures one lpc_periph cycle record per READY rising edge
// and buffers it in a first-word-fall-through FIFO with a valid/ready output.
// Optional: define LPC_CYCLE_FILTER_EN to push only addresses in
// [FILT_LO, FILT_HI]; out-of-range captures are silently ignored.
// Ports:
//   clk_i, rst_i        LCLK and synchronous active-high reset
//   tdata_i, tready_i   cycle record {addr[31:16], data[15:8], type[7:0]}, READY
//   m_data_o/m_valid_o  head record and its valid; m_ready_i accepts it
//   level_o/full_o/empty_o  occupancy status
//   drop_cnt_o, clr_drop_i  saturating overflow-drop counter and its clear
module lpc_cycle_fifo #(
    parameter int          DEPTH   = 8,
    parameter logic [15:0] FILT_LO = 16'h0000,
    parameter logic [15:0] FILT_HI = 16'hFFFF
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [31:0]                tdata_i,
    input  logic                       tready_i,
    output logic [31:0]                m_data_o,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [15:0]                drop_cnt_o,
    input  logic                       clr_drop_i
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_ready_q;
    logic [15:0] r_drop_cnt;

    logic w_cap;
    logic w_in_range;
    logic w_push_req;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

`ifdef LPC_CYCLE_FILTER_EN
    assign w_in_range = (tdata_i[31:16] >= FILT_LO) &&
                        (tdata_i[31:16] <= FILT_HI);
`else
    // Filter bounds are intentionally unused; this folds to a constant.
    logic w_unused_filt;
    assign w_unused_filt = ^{FILT_LO, FILT_HI};
    assign w_in_range    = 1'b1;
`endif

    // READY is a level; only its rising edge marks a newly completed cycle.
    assign w_cap      = tready_i & ~r_ready_q;
    assign w_push_req = w_cap & w_in_range;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_pop  = ~w_empty & m_ready_i;
    // A pop on the same edge frees the slot the push needs.
    assign w_push = w_push_req & (~w_full | w_pop);
    assign w_drop = w_push_req & w_full & ~w_pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ready_q  <= 1'b1;
            r_drop_cnt <= '0;
        end else begin
            r_ready_q <= tready_i;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (clr_drop_i) begin
                r_drop_cnt <= {15'd0, w_drop};
            end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= tdata_i;
        end
    end

    // Gate the head with empty so the output is defined before any write.
    assign m_data_o   = w_empty ? 32'd0 : r_mem[r_rd_ptr[AW-1:0]];
    assign m_valid_o  = ~w_empty;
    assign level_o    = r_wr_ptr - r_rd_ptr;
    assign full_o     = w_full;
    assign empty_o    = w_empty;
    assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_lpc_cycle_fifo.sv
// Testbench for lpc_cycle_fifo: directed and random cycles against a
// queue-based reference model.
module tb_lpc_cycle_fifo;

    localparam int          DEPTH = 4;
    localparam int          LW    = $clog2(DEPTH) + 1;
    localparam logic [15:0] F_LO  = 16'h0060;
    localparam logic [15:0] F_HI  = 16'h006F;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   tdata;
    logic          tready;
    logic [31:0]   m_data;
    logic          m_valid;
    logic          m_ready;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic [15:0]   drop_cnt;
    logic          clr_drop;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mq[$];
    int          m_drop;
    logic        m_prev;

    always #5 clk = ~clk;

    lpc_cycle_fifo #(
        .DEPTH  (DEPTH),
        .FILT_LO(F_LO),
        .FILT_HI(F_HI)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .tdata_i   (tdata),
        .tready_i  (tready),
        .m_data_o  (m_data),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .level_o   (level),
        .full_o    (full),
        .empty_o   (empty),
        .drop_cnt_o(drop_cnt),
        .clr_drop_i(clr_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] d);
`ifdef LPC_CYCLE_FILTER_EN
        return (d[31:16] >= F_LO) && (d[31:16] <= F_HI);
`else
        return 1'b1;
`endif
    endfunction

    // One clock: drive inputs, advance model by the rules, compare.
    task automatic step(input logic tr, input logic [31:0] td,
                        input logic mr, input logic clr, input logic rs);
        bit cap, pop, drop;
        tready   = tr;
        tdata    = td;
        m_ready  = mr;
        clr_drop = clr;
        rst      = rs;
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_drop = 0;
            m_prev = 1'b1;
        end else begin
            cap  = tr && !m_prev;
            pop  = mr && (mq.size() > 0);
            drop = 1'b0;
            if (pop) void'(mq.pop_front());
            if (cap && in_range(td)) begin
                if (mq.size() < DEPTH) mq.push_back(td);
                else drop = 1'b1;
            end
            if (clr) m_drop = drop ? 1 : 0;
            else if (drop && m_drop < 16'hFFFF) m_drop++;
            m_prev = tr;
        end
        #1;
        chk("valid", {31'd0, m_valid}, {31'd0, mq.size() > 0});
        chk("empty", {31'd0, empty}, {31'd0, mq.size() == 0});
        chk("full", {31'd0, full}, {31'd0, mq.size() == DEPTH});
        chk("level", {{(32-LW){1'b0}}, level}, mq.size());
        chk("drop", {16'd0, drop_cnt}, m_drop);
        if (mq.size() > 0) chk("data", m_data, mq[0]);
        else if (rs) chk("data_rst", m_data, 32'd0);
    endtask

    task automatic pulse(input logic [31:0] d, input logic mr);
        step(1'b1, d, mr, 1'b0, 1'b0);
        step(1'b0, d, mr, 1'b0, 1'b0);
    endtask

    initial begin
        m_drop = 0;
        m_prev = 1'b1;
        // reset with READY already high; no capture until seen low
        step(1'b1, 32'hDEAD0001, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hDEAD0001, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b1, 32'hDEAD0002, 1'b0, 1'b0, 1'b0);
        chk("no_cap_rst", {31'd0, empty}, 32'd1);
        step(1'b0, 32'hDEAD0003, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h12340004, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h12340005, 1'b0, 1'b0, 1'b0);
        chk("one_cap", {{(32-LW){1'b0}}, level}, 32'd1);
        chk("one_data", m_data, 32'h12340004);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // READY held 3 cycles gives exactly one record
        repeat (3) step(1'b1, 32'hF0F05A01, 1'b0, 1'b0, 1'b0);
        chk("held_lvl", {{(32-LW){1'b0}}, level}, 32'd1);
        chk("held_data", m_data, 32'hF0F05A01);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // overflow: 5 pulses into 4 entries
        for (int i = 0; i < 5; i++) pulse(i, 1'b0);
        chk("ovf_full", {31'd0, full}, 32'd1);
        chk("ovf_drop", {16'd0, drop_cnt}, 32'd1);

        // full, pop and capture on the same edge
        step(1'b1, 32'h000000AA, 1'b1, 1'b0, 1'b0);
        chk("fpp_lvl", {{(32-LW){1'b0}}, level}, DEPTH);
        chk("fpp_drop", {16'd0, drop_cnt}, 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // drop coincident with clear leaves 1; then plain clear
        step(1'b1, 32'h000000BB, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (5) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // streaming through pointer wrap
        for (int i = 0; i < 10; i++) pulse({i[15:0], 16'h0100}, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // address filter case
        pulse(32'h00601100, 1'b0);
        pulse(32'h00802200, 1'b0);
        pulse(32'h006F3300, 1'b0);
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // random traffic with occasional mid-stream reset
        for (int i = 0; i < 600; i++) begin
            logic [31:0] d;
            d = $urandom;
            if ($urandom_range(0, 3) == 0) d[31:16] = 16'h0060 + 16'($urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), d,
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
